// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/instruction path to instruction memory, hazard and
// redirect controls in, IF/ID pipeline register and halt status out.
interface fetch_stage_if;
  logic [15:0] pc;
  logic [15:0] instr_in;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  modport master (
    output pc, if_id_instr, if_id_pc, if_id_pc_plus2, if_id_valid, halted,
    input  instr_in, stall, redirect, redirect_target
  );

  modport slave (
    input  pc, if_id_instr, if_id_pc, if_id_pc_plus2, if_id_valid, halted,
    output instr_in, stall, redirect, redirect_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures the combinationally
// returned instruction into IF/ID, handles stall, redirect/flush and halt.
//
// state  | meaning
// S_RUN  | fetching; PC advances by 2 each unstalled cycle
// S_HALT | halt opcode captured; PC and IF/ID frozen until redirect or reset
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hE,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_q;
  logic [15:0] pc_plus2;
  logic [15:0] instr_q;
  logic [15:0] id_pc_q;
  logic [15:0] id_pc_plus2_q;
  logic        valid_q;
  logic        fetch_en;
  logic        is_halt;

  // Redirect has priority over everything but reset, so fetch only advances
  // when neither redirect nor stall is asserted and we are running.
  assign pc_plus2 = pc_q + 16'd2;
  assign fetch_en = !bus.redirect && !bus.stall && (state == S_RUN);
  assign is_halt  = (bus.instr_in[15:12] == HALT_OPCODE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // FSM next state: a redirect always cancels halt; halt is only detected on a real fetch.
  always_comb begin
    state_nxt = state;
    if (bus.redirect)           state_nxt = S_RUN;
    else if (fetch_en && is_halt) state_nxt = S_HALT;
  end

  // FSM and datapath outputs onto the bus.
  always_comb begin
    bus.halted         = (state == S_HALT);
    bus.pc             = pc_q;
    bus.if_id_instr    = instr_q;
    bus.if_id_pc       = id_pc_q;
    bus.if_id_pc_plus2 = id_pc_plus2_q;
    bus.if_id_valid    = valid_q;
  end

  // PC and IF/ID register: flush on redirect (link/base fields kept), capture on fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= {RESET_PC[15:1], 1'b0};
      instr_q       <= NOP_INSTR;
      id_pc_q       <= 16'h0000;
      id_pc_plus2_q <= 16'h0000;
      valid_q       <= 1'b0;
    end else if (bus.redirect) begin
      pc_q    <= bus.redirect_target & 16'hFFFE;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (fetch_en) begin
      pc_q          <= pc_plus2;
      instr_q       <= bus.instr_in;
      id_pc_q       <= pc_q;
      id_pc_plus2_q <= pc_plus2;
      valid_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/redirect/reset
// traffic, compared every cycle against a behavioural fetch model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fetch_stage_if bus();
  fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Small instruction memory, aliased on pc[8:1]; returns data same cycle.
  logic [15:0] mem [256];
  assign bus.instr_in = mem[bus.pc[8:1]];

  // Reference model state.
  logic [15:0] m_pc, m_instr, m_ipc, m_iplus;
  logic        m_valid, m_halt;

  task automatic model_step(input logic r, input logic st, input logic rd, input logic [15:0] tgt);
    logic [15:0] w;
    if (r) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_iplus = 16'h0000;
      m_valid = 1'b0; m_halt = 1'b0;
    end else if (rd) begin
      m_pc = {tgt[15:1], 1'b0}; m_instr = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
    end else if (!st && !m_halt) begin
      w = mem[m_pc[8:1]];
      m_instr = w; m_ipc = m_pc; m_iplus = m_pc + 16'd2; m_pc = m_pc + 16'd2;
      m_valid = 1'b1;
      if (w[15:12] == 4'hE) m_halt = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", bus.pc, m_pc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_pc", bus.if_id_pc, m_ipc);
    chk("if_id_pc_plus2", bus.if_id_pc_plus2, m_iplus);
    chk("if_id_valid", {15'd0, bus.if_id_valid}, {15'd0, m_valid});
    chk("halted", {15'd0, bus.halted}, {15'd0, m_halt});
  endtask

  // One clock: drive inputs after negedge, advance model, sample 1ns after posedge.
  task automatic cycle(input logic r, input logic st, input logic rd, input logic [15:0] tgt);
    @(negedge clk);
    rst = r; bus.stall = st; bus.redirect = rd; bus.redirect_target = tgt;
    model_step(r, st, rd, tgt);
    @(posedge clk);
    #1;
    chk_all();
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hE) w[15:12] = 4'h1;
      mem[i] = w;
    end
    mem[0] = 16'h012F; mem[1] = 16'h012E; mem[2] = 16'h034C; mem[3] = 16'h032D;
    mem[8'h19] = 16'hEFFF;
    rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 16'h0000;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("reset_pc", bus.pc, 16'h0000);
    chk("reset_valid", {15'd0, bus.if_id_valid}, 16'h0000);

    // Free run 4 fetches from address 0.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("run_pc", bus.pc, 16'h0008);
    chk("run_instr", bus.if_id_instr, 16'h032D);
    chk("run_ipc", bus.if_id_pc, 16'h0006);

    // Stall two cycles at pc=8, then resume up to pc=0x10.
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("stall_pc", bus.pc, 16'h0008);
    chk("stall_instr", bus.if_id_instr, 16'h032D);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("resume_ipc", bus.if_id_pc, 16'h0008);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("pre_redirect_pc", bus.pc, 16'h0010);

    // Redirect to odd target: bit 0 dropped, one bubble.
    cycle(1'b0, 1'b0, 1'b1, 16'h0025);
    chk("redir_pc", bus.pc, 16'h0024);
    chk("redir_bubble", {15'd0, bus.if_id_valid}, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("redir_target_ipc", bus.if_id_pc, 16'h0024);
    chk("redir_target_valid", {15'd0, bus.if_id_valid}, 16'h0001);

    // Stall and redirect together: redirect wins.
    cycle(1'b0, 1'b1, 1'b1, 16'h0030);
    chk("stall_redir_pc", bus.pc, 16'h0030);
    chk("stall_redir_valid", {15'd0, bus.if_id_valid}, 16'h0000);

    // Fetch the halt word at 0x32 and sit in HALT, stall toggling.
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("halt_flag", {15'd0, bus.halted}, 16'h0001);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 16'h0000);
    chk("halt_pc", bus.pc, 16'h0034);
    chk("halt_instr", bus.if_id_instr, 16'hEFFF);
    chk("halt_valid", {15'd0, bus.if_id_valid}, 16'h0001);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("unhalt_flag", {15'd0, bus.halted}, 16'h0000);
    chk("unhalt_pc", bus.pc, 16'h0000);
    chk("unhalt_bubble", {15'd0, bus.if_id_valid}, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 25),
            1'($urandom_range(0, 99) < 10),
            ($urandom_range(0, 3) == 0) ? 16'h0032 : 16'($urandom));
    end

    // Wrap at the top of the address space.
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
    chk("wrap_pc0", bus.pc, 16'hFFFE);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc1", bus.pc, 16'h0000);
    chk("wrap_plus2", bus.if_id_pc_plus2, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset during a stall.
    cycle(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("rst_stall_pc", bus.pc, 16'h0000);
    chk("rst_stall_valid", {15'd0, bus.if_id_valid}, 16'h0000);
    chk("rst_stall_halted", {15'd0, bus.halted}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
